// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - Game Boy OAM DMA sequencer (FF46 -> FE00..FE9F)
// Optional CPU lockout enabled by defining OAM_DMA_CPU_LOCKOUT_EN.
module oam_dma_controller #(
  parameter int          BYTES_PER_XFER  = 160,
  parameter int          CYCLES_PER_BYTE = 4,
  parameter logic [15:0] REG_ADDR        = 16'hFF46
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  mem_rd_data,
  output logic        dma_read_en,
  output logic [15:0] dma_src_addr,
  output logic [7:0]  dma_oam_addr,
  output logic [7:0]  dma_oam_wdata,
  output logic        dma_oam_wren,
  output logic        dma_active,
  output logic        dma_done,
  output logic        cpu_blocked,
  output logic        reg_sel,
  output logic [7:0]  reg_data_out
);

  localparam int               SUB_W    = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(CYCLES_PER_BYTE - 1);
  localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic [7:0]       LAST_IDX = 8'(BYTES_PER_XFER - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_src;
  logic [7:0]       w_src_nxt;
  logic [7:0]       r_idx;
  logic [7:0]       w_idx_nxt;
  logic [SUB_W-1:0] r_sub;
  logic [SUB_W-1:0] w_sub_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_trig;
  logic             w_slot_end;
  logic             w_last_slot;
  logic [7:0]       w_eff_src;

  assign w_trig      = cpu_wren && (cpu_addr == REG_ADDR);
  assign w_slot_end  = (r_sub == LAST_SUB);
  assign w_last_slot = (r_idx == LAST_IDX);
  // Echo RAM source pages (E0..FF) are fetched from the WRAM they mirror.
  assign w_eff_src   = (r_src >= 8'hE0) ? (r_src - 8'h20) : r_src;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_src   <= 8'h00;
      r_idx   <= 8'h00;
      r_sub   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_idx   <= w_idx_nxt;
      r_sub   <= w_sub_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_src_nxt     = r_src;
    w_idx_nxt     = r_idx;
    w_sub_nxt     = r_sub;
    w_done_nxt    = 1'b0;
    dma_active    = 1'b0;
    dma_read_en   = 1'b0;
    dma_src_addr  = 16'h0000;
    dma_oam_addr  = 8'h00;
    dma_oam_wren  = 1'b0;
    dma_oam_wdata = 8'h00;
    case (r_state)
      ST_START: begin
        dma_active = 1'b1;
        if (w_slot_end) begin
          w_state_nxt = ST_XFER;
          w_sub_nxt   = '0;
          w_idx_nxt   = 8'h00;
        end else begin
          w_sub_nxt = r_sub + SUB_ONE;
        end
      end
      ST_XFER: begin
        dma_active   = 1'b1;
        dma_read_en  = 1'b1;
        dma_src_addr = {w_eff_src, r_idx};
        dma_oam_addr = r_idx;
        if (w_slot_end) begin
          // Source address has been stable since sub-cycle 0, so read data is settled.
          dma_oam_wren  = !w_trig;
          dma_oam_wdata = w_trig ? 8'h00 : mem_rd_data;
          w_sub_nxt     = '0;
          if (w_last_slot) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 8'h00;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 8'd1;
          end
        end else begin
          w_sub_nxt = r_sub + SUB_ONE;
        end
      end
      default: begin
      end
    endcase
    // A register write restarts from any state and cancels any write or done on this edge.
    if (w_trig) begin
      w_state_nxt = ST_START;
      w_src_nxt   = cpu_data_in;
      w_idx_nxt   = 8'h00;
      w_sub_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  assign dma_done     = r_done;
  assign reg_sel      = (cpu_addr == REG_ADDR);
  assign reg_data_out = r_src;

`ifdef OAM_DMA_CPU_LOCKOUT_EN
  logic w_in_hram;
  assign w_in_hram   = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign cpu_blocked = dma_active && !w_in_hram && !reg_sel;
`else
  assign cpu_blocked = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - scoreboard bench for oam_dma_controller
module tb_oam_dma_controller;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  oaddr;
    logic [7:0]  wdata;
    logic [15:0] src;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wren = 1'b0;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  mem_rd_data;
  logic        dma_read_en;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_oam_addr;
  logic [7:0]  dma_oam_wdata;
  logic        dma_oam_wren;
  logic        dma_active;
  logic        dma_done;
  logic        cpu_blocked;
  logic        reg_sel;
  logic [7:0]  reg_data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];
  wr_t exp_q[$];
  wr_t obs_q[$];
  int  exp_done[$];
  int  obs_done[$];
  wr_t mon_w;

  oam_dma_controller dut (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
    .cpu_data_in(cpu_data_in), .mem_rd_data(mem_rd_data), .dma_read_en(dma_read_en),
    .dma_src_addr(dma_src_addr), .dma_oam_addr(dma_oam_addr), .dma_oam_wdata(dma_oam_wdata),
    .dma_oam_wren(dma_oam_wren), .dma_active(dma_active), .dma_done(dma_done),
    .cpu_blocked(cpu_blocked), .reg_sel(reg_sel), .reg_data_out(reg_data_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) mem_rd_data <= mem[dma_read_en ? dma_src_addr : cpu_addr];

  always @(negedge clock) begin
    if (dma_oam_wren) begin
      mon_w.cyc   = 32'(cyc);
      mon_w.oaddr = dma_oam_addr;
      mon_w.wdata = dma_oam_wdata;
      mon_w.src   = dma_src_addr;
      obs_q.push_back(mon_w);
      oam[dma_oam_addr] = dma_oam_wdata;
    end
    if (dma_done) obs_done.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drop expected events that a trigger or reset on the coming edge cancels.
  task automatic prune();
    while (exp_q.size() > 0 && int'(exp_q[$].cyc) >= cyc) void'(exp_q.pop_back());
    while (exp_done.size() > 0 && exp_done[$] >= cyc) void'(exp_done.pop_back());
  endtask

  task automatic arm(input logic [7:0] v);
    logic [7:0]  eff;
    logic [15:0] a;
    wr_t         w;
    int          t;
    eff = (v >= 8'hE0) ? v - 8'h20 : v;
    t = cyc + 1;
    for (int k = 0; k < 160; k++) begin
      a = {eff, 8'(k)};
      w.cyc = 32'(t + 7 + 4 * k);
      w.oaddr = 8'(k);
      w.wdata = mem[a];
      w.src = a;
      exp_q.push_back(w);
    end
    exp_done.push_back(t + 644);
  endtask

  task automatic cpu_write(input logic [7:0] v);
    prune();
    arm(v);
    cpu_addr = 16'hFF46;
    cpu_data_in = v;
    cpu_wren = 1'b1;
    step();
    cpu_wren = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (dma_active && n < 2000) begin
      n++;
      step();
    end
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_addr = 16'hFF46;
    step(); step(); step();
    checks++;
    if ({dma_active, dma_read_en, dma_src_addr, dma_oam_addr, dma_oam_wren, dma_oam_wdata,
         dma_done, cpu_blocked, reg_data_out} !== 56'h0) begin
      errors++;
      $display("FAIL reset_outputs got act=%b rd=%b src=%h oa=%h wr=%b wd=%h done=%b blk=%b reg=%h exp all zero",
               dma_active, dma_read_en, dma_src_addr, dma_oam_addr, dma_oam_wren, dma_oam_wdata,
               dma_done, cpu_blocked, reg_data_out);
    end
    checks++;
    if (reg_sel !== 1'b1) begin errors++; $display("FAIL reset_reg_sel got %b exp 1", reg_sel); end
    reset = 1'b0;
    cpu_addr = 16'h0000;
    step();
  endtask

  task automatic test_copy();
    int  n;
    wr_t e, o;
    cpu_write(8'hC1);
    checks++;
    if (dma_active !== 1'b1) begin errors++; $display("FAIL copy_active_rise got %b exp 1", dma_active); end
    wait_idle(n);
    checks++;
    if (n != 644) begin errors++; $display("FAIL copy_active_len got %0d exp 644", n); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL copy_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL copy_wr got %h exp %h", o, e); end
    end
    checks++;
    if (obs_done.size() != 1 || exp_done.size() != 1 || obs_done[0] != exp_done[0]) begin
      errors++; $display("FAIL copy_done got n=%0d exp n=%0d", obs_done.size(), exp_done.size());
    end
    exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
    for (int i = 0; i < 160; i++) begin
      logic [15:0] a;
      a = 16'hC100 + 16'(i);
      checks++;
      if (oam[i] !== mem[a]) begin errors++; $display("FAIL copy_oam[%0d] got %h exp %h", i, oam[i], mem[a]); end
    end
  endtask

  task automatic test_echo();
    int  n;
    wr_t e, o;
    cpu_write(8'hF0);
    checks++;
    if (reg_data_out !== 8'hF0) begin errors++; $display("FAIL echo_reg got %h exp f0", reg_data_out); end
    cpu_addr = 16'hFF46;
    #1;
    checks++;
    if (reg_sel !== 1'b1) begin errors++; $display("FAIL echo_reg_sel got %b exp 1", reg_sel); end
    cpu_addr = 16'h0000;
    wait_idle(n);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL echo_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL echo_wr got %h exp %h", o, e); end
    end
    checks++;
    if (obs_done.size() != 1) begin errors++; $display("FAIL echo_done got %0d exp 1", obs_done.size()); end
    exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  task automatic test_restart();
    int  n, b;
    wr_t e, o;
    cpu_write(8'hC3);
    b = 0;
    while (obs_q.size() < 50 && b < 1000) begin b++; step(); end
    checks++;
    if (obs_q.size() != 50) begin errors++; $display("FAIL restart_reach50 got %0d exp 50", obs_q.size()); end
    cpu_write(8'h80);
    wait_idle(n);
    checks++;
    if (n != 644) begin errors++; $display("FAIL restart_active_len got %0d exp 644", n); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL restart_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL restart_wr got %h exp %h", o, e); end
    end
    checks++;
    if (obs_done.size() != 1 || exp_done.size() != 1 || obs_done[0] != exp_done[0]) begin
      errors++; $display("FAIL restart_done got n=%0d exp 1", obs_done.size());
    end
    exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  task automatic test_lockout();
    int          n;
    wr_t         e, o;
    logic [15:0] addrs [8];
    logic        blk   [8];
    logic        expb;
    addrs = '{16'hFF90, 16'hC000, 16'hFE00, 16'hFF46, 16'hFFFF, 16'hFF80, 16'hFFFE, 16'hFF7F};
    blk   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cpu_addr = 16'hC000;
    #1;
    checks++;
    if (cpu_blocked !== 1'b0) begin errors++; $display("FAIL lock_idle got %b exp 0", cpu_blocked); end
    cpu_write(8'hC0);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        cpu_addr = addrs[i];
        #1;
`ifdef OAM_DMA_CPU_LOCKOUT_EN
        expb = blk[i];
`else
        expb = 1'b0;
`endif
        checks++;
        if (cpu_blocked !== expb) begin
          errors++; $display("FAIL lock_addr_%h got %b exp %b", addrs[i], cpu_blocked, expb);
        end
      end
      repeat (20) step();
    end
    cpu_addr = 16'h0000;
    wait_idle(n);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL lock_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL lock_wr got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  task automatic test_reset_mid();
    int  b;
    wr_t e, o;
    cpu_write(8'hC5);
    b = 0;
    while (obs_q.size() < 80 && b < 1000) begin b++; step(); end
    checks++;
    if (obs_q.size() != 80) begin errors++; $display("FAIL rmid_reach80 got %0d exp 80", obs_q.size()); end
    prune();
    reset = 1'b1;
    step();
    checks++;
    if ({dma_active, dma_oam_wren, dma_done, dma_read_en} !== 4'b0) begin
      errors++; $display("FAIL rmid_outputs got act=%b wr=%b done=%b rd=%b exp 0", dma_active, dma_oam_wren, dma_done, dma_read_en);
    end
    checks++;
    if (reg_data_out !== 8'h00) begin errors++; $display("FAIL rmid_reg got %h exp 00", reg_data_out); end
    reset = 1'b0;
    repeat (700) step();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rmid_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rmid_wr got %h exp %h", o, e); end
    end
    checks++;
    if (obs_done.size() != 0) begin errors++; $display("FAIL rmid_done got %0d exp 0", obs_done.size()); end
    exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  task automatic test_back_to_back();
    int  n, b, c;
    wr_t e, o;
    cpu_write(8'h45);
    b = 0;
    while (obs_q.size() < 159 && b < 1000) begin b++; step(); end
    checks++;
    if (obs_q.size() != 159) begin errors++; $display("FAIL b2b_reach159 got %0d exp 159", obs_q.size()); end
    c = int'(obs_q[obs_q.size() - 1].cyc) + 4;
    b = 0;
    while (cyc < c && b < 10) begin b++; step(); end
    prune();
    arm(8'h12);
    cpu_addr = 16'hFF46;
    cpu_data_in = 8'h12;
    cpu_wren = 1'b1;
    #1;
    checks++;
    if (dma_oam_wren !== 1'b0) begin errors++; $display("FAIL b2b_wr_suppress got %b exp 0", dma_oam_wren); end
    step();
    cpu_wren = 1'b0;
    cpu_addr = 16'h0000;
    wait_idle(n);
    checks++;
    if (n != 644) begin errors++; $display("FAIL b2b_active_len got %0d exp 644", n); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_wr got %h exp %h", o, e); end
    end
    checks++;
    if (obs_done.size() != 1 || exp_done.size() != 1 || obs_done[0] != exp_done[0]) begin
      errors++; $display("FAIL b2b_done got n=%0d exp 1", obs_done.size());
    end
    exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + (a >> 8) * 13 + 1);
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    test_reset();
    test_copy();
    test_echo();
    test_restart();
    test_lockout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
Sequences the Game Boy OAM DMA. A CPU write to register FF46 copies 160 bytes from {FF46 value, 8'h00} into OAM FE00–FE9F. While the copy runs, the block owns the memory map's source-read and OAM-write paths, and locks the CPU out of everything except HRAM and FF46. It sits beside the memory map and the CPU. The memory map muxes dma_src_addr onto its CPU-side address whenever dma_read_en is high.

Parameters:
BYTES_PER_XFER, 160, number of bytes copied per DMA.
CYCLES_PER_BYTE, 4, clocks per byte slot (one machine cycle); must be >= 2.
REG_ADDR, 16'hFF46, CPU address of the DMA source register.

Ports:
clock  in  1  system clock, all state changes on its rising edge
reset  in  1  synchronous, active-high reset
cpu_addr  in  16  CPU bus address
cpu_wren  in  1  CPU write strobe
cpu_data_in  in  8  CPU write data
mem_rd_data  in  8  source-byte read data from memory map (1-clock synchronous latency)
dma_read_en  out  1  memory map must use dma_src_addr for its CPU-side read port
dma_src_addr  out  16  source byte address
dma_oam_addr  out  8  OAM write address
dma_oam_wdata  out  8  OAM write data
dma_oam_wren  out  1  OAM write strobe
dma_active  out  1  DMA in progress (START or XFER)
dma_done  out  1  one-clock pulse after the final OAM write
cpu_blocked  out  1  memory map returns 8'hFF to the CPU and suppresses CPU writes
reg_sel  out  1  cpu_addr == REG_ADDR
reg_data_out  out  8  FF46 readback

Behaviour:
- Reset: state=IDLE; src_reg=8'h00; slot index=0; sub-cycle=0. All outputs are 0 except reg_sel, which stays combinational.
- Trigger: cpu_wren && cpu_addr==REG_ADDR on an edge. That edge loads src_reg <= cpu_data_in, clears index and sub-cycle, and enters START. The trigger is accepted in any state.
- reg_data_out = src_reg at all times.
- States:
  - IDLE: outputs 0. Trigger -> START.
  - START: one dead slot of CYCLES_PER_BYTE clocks. dma_active=1, dma_read_en=0, no OAM writes. At the last sub-cycle -> XFER with index 0.
  - XFER, slot i (0..BYTES_PER_XFER-1):
    - dma_read_en=1.
    - eff_src = src_reg >= 8'hE0 ? src_reg - 8'h20 : src_reg (echo remap into C000–DFFF).
    - dma_src_addr = {eff_src, i[7:0]}, held for the whole slot.
    - dma_oam_addr = i[7:0].
    - At sub-cycle CYCLES_PER_BYTE-1: dma_oam_wren=1 and dma_oam_wdata=mem_rd_data. Data is valid because the address has been stable >= 1 clock.
    - After the write of the last slot -> IDLE, and dma_done=1 for the following single clock.
- Sub-cycle counter runs 0..CYCLES_PER_BYTE-1 and wraps. The index increments only at the wrap.
- Total dma_active duration = (1+BYTES_PER_XFER)*CYCLES_PER_BYTE clocks. Default is 644.
- Restart: a trigger during START or XFER aborts the current copy with no further writes and restarts START with the new source. A trigger on the same edge as a slot write suppresses that write. dma_done is not pulsed for an aborted copy.
- A trigger on the edge where dma_done would fire suppresses dma_done.
- cpu_blocked = dma_active && !(cpu_addr in FF80..FFFE) && !reg_sel. This is combinational.
- Reset mid-copy: immediately IDLE, all outputs 0, no pending write or done.

Optional Feature:
OAM_DMA_CPU_LOCKOUT_EN:
- Defined: cpu_blocked behaves as in Behaviour.
- Undefined: cpu_blocked is tied to 0 and the CPU accesses the bus freely during DMA. dma_read_en is unchanged, so the memory map still gives DMA priority on the shared read port. This mode is for bring-up and debug only.

Test Plan:
- Reset, then write 8'hC1 to FF46 -> dma_active rises next clock and stays high 644 clocks. 160 dma_oam_wren pulses, one every 4 clocks; first on clock 8 after the trigger edge (START clocks 1–4, write at slot-0 sub-cycle 3 = clock 8); last on clock 644, dma_done on clock 645. OAM[i]==WRAM[C100+i] for all i.
- Write 8'hF0 -> dma_src_addr runs D000..D09F (echo remap). reg_data_out reads 8'hF0.
- Mid-copy (after 50 writes) write 8'h80 -> no further writes from the old source. A new 644-clock run starts with dma_src_addr 8000 and dma_oam_addr 0. A single dma_done at the end.
- During DMA, CPU at cpu_addr FF90 -> cpu_blocked=0. At C000 or FE00 -> cpu_blocked=1. At FF46 -> cpu_blocked=0. With the macro undefined, cpu_blocked=0 for all addresses.
- Assert reset at slot 80 -> next clock: dma_active=0, dma_oam_wren=0, reg_data_out=8'h00, no dma_done.
- Trigger on the same edge as slot 159's write -> that write is suppressed, no dma_done, and the restart proceeds normally.
